// File: rtl/lfsr_stream_gen.sv
// Serial pseudo-random bit source: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
// under an IDLE/RUN/PAUSE controller, with period tracking against the loaded seed.
module lfsr_stream_gen #(
   parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        load,
   input  logic [15:0] seed,
   output logic        test_bit,
   output logic        bit_valid,
   output logic        max_tick_reg,
   output logic        busy,
   output logic [15:0] period_count
);

   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   state_t              state;
   state_t              state_next;
   logic [DATA_W-1:0]   lfsr;
   logic [DATA_W-1:0]   seed_reg;
   logic [DATA_W-1:0]   lfsr_adv;
   logic [DATA_W-1:0]   seed_fixed;
   logic                emit;
   logic                load_ok;

   function automatic logic [DATA_W-1:0] lfsr_step(input logic [DATA_W-1:0] q);
      return {q[DATA_W-2:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
   endfunction

   // The all-zero state is a fixed point of the LFSR, so it is never allowed in.
   function automatic logic [DATA_W-1:0] seed_sanitize(input logic [DATA_W-1:0] s);
      return (s == '0) ? {{(DATA_W-1){1'b0}}, 1'b1} : s;
   endfunction

   assign lfsr_adv   = lfsr_step(lfsr);
   assign seed_fixed = seed_sanitize(seed);

   always_comb begin
      state_next = state;
      emit       = 1'b0;
      load_ok    = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               load_ok = 1'b1;
            end else if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (stop) begin
               state_next = PAUSE;
            end else begin
               emit = 1'b1;
            end
         end
         PAUSE: begin
            if (load) begin
               load_ok    = 1'b1;
               state_next = IDLE;
            end else if (start && !stop) begin
               state_next = RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= (state_next == RUN);
      end
   end

   // Emission stage: one bit per RUN edge; a stop edge emits nothing so the
   // first PAUSE cycle already shows bit_valid low.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr         <= SEED_DEFAULT;
         seed_reg     <= SEED_DEFAULT;
         test_bit     <= 1'b0;
         bit_valid    <= 1'b0;
         max_tick_reg <= 1'b0;
         period_count <= '0;
      end else begin
         bit_valid    <= emit;
         max_tick_reg <= emit && (lfsr_adv == seed_reg);
         if (load_ok) begin
            lfsr         <= seed_fixed;
            seed_reg     <= seed_fixed;
            period_count <= '0;
         end else if (emit) begin
            test_bit <= lfsr[DATA_W-1];
            lfsr     <= lfsr_adv;
            if (lfsr_adv == seed_reg) begin
               period_count <= '0;
            end else begin
               period_count <= period_count + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lfsr_stream_gen.sv
// Directed + randomized bench for lfsr_stream_gen; the reference derives the bit
// stream from the polynomial's bit recurrence and tracks period position arithmetically.
module tb_lfsr_stream_gen;

   localparam logic [15:0] SEED_DEF = 16'hACE1;
   localparam int PERIOD = 65535;
   localparam int M_IDLE = 0;
   localparam int M_RUN = 1;
   localparam int M_PAUSE = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        stop;
   logic        load;
   logic [15:0] seed;
   logic        test_bit;
   logic        bit_valid;
   logic        max_tick_reg;
   logic        busy;
   logic [15:0] period_count;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   bit          m_x [0:PERIOD+15];
   int          m_idx;
   int          m_state;
   logic        e_bit, e_valid, e_tick, e_busy;
   logic [15:0] e_cnt;

   lfsr_stream_gen #(.SEED_DEFAULT(SEED_DEF)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .load(load), .seed(seed),
      .test_bit(test_bit), .bit_valid(bit_valid), .max_tick_reg(max_tick_reg),
      .busy(busy), .period_count(period_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Output stream x[n]: first 16 bits are the seed MSB-first, then
   // x[n+16] = x[n] ^ x[n+2] ^ x[n+3] ^ x[n+5].
   task automatic m_load(input logic [15:0] s);
      logic [15:0] f;
      f = (s == 16'h0000) ? 16'h0001 : s;
      for (int k = 0; k < 16; k++) m_x[k] = f[15-k];
      for (int t = 0; t < PERIOD; t++) m_x[t+16] = m_x[t] ^ m_x[t+2] ^ m_x[t+3] ^ m_x[t+5];
      m_idx = 0;
      e_cnt = 16'd0;
   endtask

   task automatic m_reset();
      m_load(SEED_DEF);
      m_state = M_IDLE;
      e_bit = 1'b0; e_valid = 1'b0; e_tick = 1'b0; e_busy = 1'b0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".test_bit"}, 32'(test_bit), 32'(e_bit));
      chk({tag, ".bit_valid"}, 32'(bit_valid), 32'(e_valid));
      chk({tag, ".max_tick"}, 32'(max_tick_reg), 32'(e_tick));
      chk({tag, ".busy"}, 32'(busy), 32'(e_busy));
      chk({tag, ".period_count"}, 32'(period_count), 32'(e_cnt));
   endtask

   task automatic tick();
      @(posedge clk);
      if (m_state == M_RUN) begin
         if (stop) begin
            m_state = M_PAUSE;
            e_valid = 1'b0; e_tick = 1'b0;
         end else begin
            e_bit = m_x[m_idx % PERIOD];
            m_idx++;
            e_valid = 1'b1;
            e_cnt = 16'(m_idx % PERIOD);
            e_tick = (m_idx % PERIOD == 0);
         end
      end else begin
         e_valid = 1'b0; e_tick = 1'b0;
         if (load) begin
            m_load(seed);
            m_state = M_IDLE;
         end else if (start && (m_state == M_IDLE || !stop)) begin
            m_state = M_RUN;
         end
      end
      e_busy = (m_state == M_RUN);
      #1;
      check_all("cyc");
   endtask

   initial begin
      logic [31:0] first32, vec32;
      logic [15:0] cnt_at_tick;
      int ticks_seen, tick_at, r;

      reset = 1'b0; start = 1'b0; stop = 1'b0; load = 1'b0; seed = 16'h0000;
      m_reset();
      #3;
      check_all("rst_async");
      repeat (2) begin @(posedge clk); #1; check_all("rst_hold"); end
      reset = 1'b1;
      repeat (3) tick();

      // seed 1: fifteen zeros then a one; count 16 after 16 bits
      seed = 16'h0001; load = 1'b1; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      chk("first_edge_no_valid", 32'(bit_valid), 32'd0);
      first32 = '0;
      for (int i = 0; i < 32; i++) begin
         tick();
         first32 = {first32[30:0], test_bit};
         if (i == 15) chk("seed1_cnt16", 32'(period_count), 32'd16);
      end
      chk("seed1_first16", 32'(first32[31:16]), 32'h0001);

      // remainder of the full period plus the start of the next one
      ticks_seen = 0; tick_at = -1; cnt_at_tick = 16'hFFFF; vec32 = '0;
      for (int i = 32; i < PERIOD + 32; i++) begin
         tick();
         if (max_tick_reg) begin ticks_seen++; tick_at = i + 1; cnt_at_tick = period_count; end
         if (i >= PERIOD) vec32 = {vec32[30:0], test_bit};
      end
      chk("max_tick_once", 32'(ticks_seen), 32'd1);
      chk("max_tick_pos", 32'(tick_at), 32'(PERIOD));
      chk("cnt_at_tick", 32'(cnt_at_tick), 32'd0);
      chk("period2_repeat", vec32, first32);

      // zero seed behaves as seed 1
      stop = 1'b1; tick(); stop = 1'b0; tick();
      seed = 16'h0000; load = 1'b1; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      vec32 = '0;
      for (int i = 0; i < 32; i++) begin tick(); vec32 = {vec32[30:0], test_bit}; end
      chk("seed0_eq_seed1", vec32, first32);

      // 100 bits, 7-cycle pause, resume
      stop = 1'b1; tick(); stop = 1'b0;
      seed = 16'($urandom); load = 1'b1; tick(); load = 1'b0;
      start = 1'b1; tick(); start = 1'b0;
      repeat (100) tick();
      stop = 1'b1; tick();
      for (int i = 0; i < 7; i++) begin
         tick();
         chk("pause_cnt", 32'(period_count), 32'd100);
         chk("pause_vld", 32'(bit_valid), 32'd0);
      end
      stop = 1'b0; start = 1'b1; tick(); start = 1'b0;
      repeat (60) tick();

      // start+load together in IDLE, then load during RUN
      stop = 1'b1; tick(); stop = 1'b0;
      seed = 16'($urandom); load = 1'b1; tick();
      start = 1'b1; seed = 16'($urandom);
      repeat (3) begin tick(); chk("ld_start_busy", 32'(busy), 32'd0); end
      load = 1'b0; start = 1'b0; tick();
      chk("ld_start_cnt", 32'(period_count), 32'd0);
      start = 1'b1; tick(); start = 1'b0;
      repeat (20) tick();
      load = 1'b1; seed = 16'($urandom); repeat (10) tick(); load = 1'b0;
      repeat (20) tick();

      // randomized control traffic
      repeat (600) begin
         r = $urandom_range(0, 99);
         start = (r < 20);
         stop = (r >= 20 && r < 30);
         load = (r >= 30 && r < 36);
         seed = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         tick();
      end
      start = 1'b0; stop = 1'b0; load = 1'b0;

      // asynchronous reset mid-RUN
      start = 1'b1; tick(); start = 1'b0;
      repeat (10) tick();
      #2; reset = 1'b0; #1;
      m_reset();
      check_all("rst_mid");
      @(posedge clk); #1; check_all("rst_mid_hold");
      reset = 1'b1;
      tick();
      start = 1'b1; tick(); start = 1'b0;
      vec32 = '0;
      for (int i = 0; i < 16; i++) begin tick(); vec32 = {vec32[30:0], test_bit}; end
      chk("rst_default_seq", 32'(vec32[15:0]), 32'(SEED_DEF));
      repeat (24) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lfsr_stream_gen.md
LFSR_STREAM_GEN -- requirements
Module: lfsr_stream_gen

Interface
REQ-001 Parameter SEED_DEFAULT, 16'hACE1, seed loaded into the LFSR and the seed register on reset.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 resets all state immediately.
REQ-004 start  input  1  level; requests generation from IDLE or PAUSE.
REQ-005 stop  input  1  level; requests a pause from RUN.
REQ-006 load  input  1  level; requests a seed load while in IDLE or PAUSE.
REQ-007 seed  input  16  seed value captured on an accepted load.
REQ-008 test_bit  output  1  registered emitted bit; meaningful only when bit_valid=1.
REQ-009 bit_valid  output  1  registered; 1 in each cycle that test_bit carries a new bit.
REQ-010 max_tick_reg  output  1  registered one-cycle pulse coincident with the last bit of a full 65535-bit period.
REQ-011 busy  output  1  registered; 1 while the FSM is in RUN.
REQ-012 period_count  output  16  bits emitted so far in the current period.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE.
REQ-014 Transitions:
- IDLE to RUN when start=1.
- RUN to PAUSE when stop=1.
- PAUSE to RUN when start=1 and stop=0.
- PAUSE to IDLE when load=1, after the seed is loaded.
REQ-015 In RUN, stop SHALL have priority over start; load SHALL be ignored.
REQ-016 In IDLE or PAUSE, load SHALL have priority over start; with load=1 the FSM SHALL NOT enter RUN in that cycle.
REQ-017 The LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1:
- fb = q[15]^q[13]^q[12]^q[10]
- next = {q[14:0], fb}
REQ-018 On an accepted load, the LFSR and seed register SHALL take seed, and period_count SHALL clear to 0.
REQ-019 A seed of 16'h0000 SHALL be replaced by 16'h0001 to prevent lockup.
REQ-020 Each rising edge in RUN (after the transition edge), the following SHALL update together:
- test_bit takes q[15]
- bit_valid goes to 1
- the LFSR advances
REQ-021 The first bit_valid SHALL occur on the second rising edge after start is sampled in IDLE, i.e. one cycle of latency.
REQ-022 In the cycle after leaving RUN, bit_valid SHALL be 0; in IDLE and PAUSE, test_bit SHALL hold its last value.
REQ-023 On each emitted bit, where next == seed register:
- max_tick_reg SHALL go to 1 and period_count SHALL clear to 0.
- Otherwise, max_tick_reg SHALL go to 0 and period_count SHALL increment by 1.
- The maximum value SHALL be 65534 before wrap.
REQ-024 max_tick_reg SHALL be 0 in every cycle without an emitted bit.
REQ-025 PAUSE SHALL preserve LFSR state and period_count; resume SHALL continue the sequence without a skipped or repeated bit.
REQ-026 The seed register SHALL change only on reset or an accepted load.

Reset
REQ-027 While reset=0, the outputs SHALL hold these values regardless of clk:
- state = IDLE
- LFSR = SEED_DEFAULT
- seed register = SEED_DEFAULT
- test_bit = 0, bit_valid = 0, max_tick_reg = 0, busy = 0
- period_count = 0
REQ-028 Reset asserted mid-RUN SHALL abort generation with no further bit_valid.
REQ-029 After reset deassertion, the block SHALL idle until start.

Verification
REQ-030 Load seed=16'h0001, then start: emitted bits 1 to 15 = 0, bit 16 = 1; period_count = 16 after the 16th bit.
REQ-031 seed=16'h0001 with continuous RUN:
- max_tick_reg pulses exactly once per 65535 bit_valid cycles, coincident with the 65535th bit.
- period_count reads 0 in that same cycle.
- The next period repeats identically.
REQ-032 Load seed=16'h0000, then run: the sequence is identical to the seed=16'h0001 sequence.
REQ-033 Run 100 bits, stop for 7 cycles, then start:
- The concatenated stream equals an uninterrupted reference stream.
- bit_valid = 0 during the pause.
- period_count = 100 throughout the pause.
REQ-034 Assert start and load together in IDLE, and load while in RUN:
- With both asserted in IDLE, the seed loads, busy stays 0, and the FSM remains in IDLE.
- With load in RUN, the load is ignored and the sequence is unchanged.
REQ-035 Assert reset=0 mid-RUN between clock edges: all outputs clear immediately; after release, start reproduces the SEED_DEFAULT sequence from its first bit.
